fsm_ctrl_multi: RTL and testbench

Parametrised multi-channel appliance-cycle controller, the next generation of the single-unit project FSM. It runs CH independent channels through IDLE → WAIT → FILL → RUN → DRAIN → DONE using programmable cycle-count timers. A single shared inlet is arbitrated so at most one channel is in FILL at a time. A global pause toggle and master enable apply to every channel.

---
 rtl/fsm_ctrl_multi_pkg.sv | 19 +
 rtl/fsm_ctrl_multi_if.sv | 22 ++
 rtl/fsm_ctrl_multi_chan.sv | 97 +++++++++
 rtl/fsm_ctrl_multi.sv | 106 ++++++++++
 tb/tb_fsm_ctrl_multi.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_ctrl_multi_pkg.sv
// Shared definitions for the multi-channel appliance-cycle controller:
// state codes, the state type and the RUN dwell helper.
package fsm_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_WAIT  = 3'd1;
    localparam state_t ST_FILL  = 3'd2;
    localparam state_t ST_RUN   = 3'd3;
    localparam state_t ST_DRAIN = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // RUN dwell in cycles for a given program select.
    function automatic int run_dwell(input int run_base, input logic [1:0] prog);
        return run_base * (int'(prog) + 1);
    endfunction

endpackage

// File: rtl/fsm_ctrl_multi_if.sv
// Control/status bundle of fsm_ctrl_multi.
//   en, start[CH], pause, prog[2]       : driven by the master (host side)
//   state[3*CH], busy, done, paused,
//   any_busy                            : driven by the slave (controller)
interface fsm_ctrl_multi_if #(
    parameter int CH = 2
);
    logic            en;
    logic [CH-1:0]   start;
    logic            pause;
    logic [1:0]      prog;
    logic [3*CH-1:0] state;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   done;
    logic            paused;
    logic            any_busy;

    modport master (output en, start, pause, prog,
                    input  state, busy, done, paused, any_busy);
    modport slave  (input  en, start, pause, prog,
                    output state, busy, done, paused, any_busy);
endinterface

// File: rtl/fsm_ctrl_multi_chan.sv
// One channel of the appliance-cycle controller: state register, dwell
// timer and latched program select.
//   clk, rst_n : clock, async active-low reset
//   en         : low forces IDLE and clears the timer
//   paused     : freezes the timer and blocks IDLE->WAIT
//   grant      : inlet granted, WAIT->FILL
//   start      : start request, sampled in IDLE
//   prog       : program select, latched on IDLE->WAIT
//   state      : current state code
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | waiting for start
// WAIT  | waiting for the shared inlet
// FILL  | inlet owned, FILL_T cycles
// RUN   | RUN_BASE*(prog+1) cycles
// DRAIN | DRAIN_T cycles
// DONE  | one cycle, done pulse, then IDLE
// 6, 7  | illegal, back to IDLE
module fsm_ctrl_chan
    import fsm_ctrl_pkg::*;
#(
    parameter int TW       = 4,
    parameter int FILL_T   = 2,
    parameter int RUN_BASE = 3,
    parameter int DRAIN_T  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       paused,
    input  logic       grant,
    input  logic       start,
    input  logic [1:0] prog,
    output state_t     state
);
    localparam logic [TW-1:0] FILL_LD  = TW'(FILL_T - 1);
    localparam logic [TW-1:0] DRAIN_LD = TW'(DRAIN_T - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    prog_q, prog_d;
    logic          tc;
    logic [TW-1:0] run_ld;

    assign tc     = (timer_q == '0);
    assign run_ld = TW'(run_dwell(RUN_BASE, prog_q) - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            prog_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            prog_q  <= prog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start && !paused) state_d = ST_WAIT;
                ST_WAIT:  if (grant)            state_d = ST_FILL;
                ST_FILL:  if (tc && !paused)    state_d = ST_RUN;
                ST_RUN:   if (tc && !paused)    state_d = ST_DRAIN;
                ST_DRAIN: if (tc && !paused)    state_d = ST_DONE;
                default:                        state_d = ST_IDLE;
            endcase
        end
    end

    // Timer loads dwell-1 on entry to each timed state and counts to zero.
    always_comb begin
        timer_d = timer_q;
        prog_d  = prog_q;
        if (!en) begin
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start && !paused) prog_d = prog;
                ST_WAIT: if (grant) timer_d = FILL_LD;
                ST_FILL: if (!paused) timer_d = tc ? run_ld : timer_q - 1'b1;
                ST_RUN:  if (!paused) timer_d = tc ? DRAIN_LD : timer_q - 1'b1;
                ST_DRAIN: if (!paused) timer_d = tc ? '0 : timer_q - 1'b1;
                default: timer_d = '0;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/fsm_ctrl_multi.sv
// Multi-channel appliance-cycle controller top level: pause toggle,
// fixed-priority (lowest index) inlet arbiter, CH channel instances and
// status packing.
//   clk, rst_n : clock, async active-low reset
//   bus        : fsm_ctrl_multi_if slave (en, start, pause, prog in;
//                state, busy, done, paused, any_busy out)
module fsm_ctrl_multi
    import fsm_ctrl_pkg::*;
#(
    parameter int CH       = 2,
    parameter int TW       = 4,
    parameter int FILL_T   = 2,
    parameter int RUN_BASE = 3,
    parameter int DRAIN_T  = 2
) (
    input logic               clk,
    input logic               rst_n,
    fsm_ctrl_multi_if.slave   bus
);
    if (CH < 1 || CH > 8 || FILL_T < 1 || DRAIN_T < 1 ||
        RUN_BASE * 4 > (1 << TW) || FILL_T > (1 << TW) || DRAIN_T > (1 << TW))
    begin : g_param_err
        $error("fsm_ctrl_multi: parameters out of range for TW");
    end

    logic            pause_q, pause_d;
    logic            paused_q, paused_d;
    logic [CH-1:0]   grant;
    logic            fill_busy;
    logic            found;
    state_t          ch_state [CH];
    logic [3*CH-1:0] state_vec;
    logic [CH-1:0]   busy_vec;
    logic [CH-1:0]   done_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_q  <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            pause_q  <= pause_d;
            paused_q <= paused_d;
        end
    end

    // Channels see paused_q, so a toggle and an expiry on the same edge
    // resolve against the pre-toggle value.
    always_comb begin
        pause_d  = bus.pause;
        paused_d = paused_q ^ (bus.pause & ~pause_q);
    end

    always_comb begin
        fill_busy = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (ch_state[i] == ST_FILL) fill_busy = 1'b1;
        end
    end

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < CH; i++) begin
            if (ch_state[i] == ST_WAIT && !found) begin
                found    = 1'b1;
                grant[i] = !fill_busy && !paused_q;
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        fsm_ctrl_chan #(
            .TW       (TW),
            .FILL_T   (FILL_T),
            .RUN_BASE (RUN_BASE),
            .DRAIN_T  (DRAIN_T)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (bus.en),
            .paused (paused_q),
            .grant  (grant[g]),
            .start  (bus.start[g]),
            .prog   (bus.prog),
            .state  (ch_state[g])
        );
    end

    always_comb begin
        state_vec = '0;
        busy_vec  = '0;
        done_vec  = '0;
        for (int i = 0; i < CH; i++) begin
            state_vec[3*i +: 3] = ch_state[i];
            busy_vec[i] = (ch_state[i] != ST_IDLE) && (ch_state[i] != ST_DONE);
            done_vec[i] = (ch_state[i] == ST_DONE);
        end
    end

    assign bus.state    = state_vec;
    assign bus.busy     = busy_vec;
    assign bus.done     = done_vec;
    assign bus.paused   = paused_q;
    assign bus.any_busy = |busy_vec;

endmodule

// File: tb/tb_fsm_ctrl_multi.sv
module tb_fsm_ctrl_multi;
    localparam int CH       = 2;
    localparam int TW       = 4;
    localparam int FILL_T   = 2;
    localparam int RUN_BASE = 3;
    localparam int DRAIN_T  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fsm_ctrl_multi_if #(.CH(CH)) bus ();

    fsm_ctrl_multi #(
        .CH(CH), .TW(TW), .FILL_T(FILL_T), .RUN_BASE(RUN_BASE), .DRAIN_T(DRAIN_T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase number 0..5 and cycles remaining in the phase.
    int m_st   [CH];
    int m_left [CH];
    int m_prog [CH];
    bit m_paused;
    bit m_pause_prev;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_st[i] = 0; m_left[i] = 0; m_prog[i] = 0;
        end
        m_paused     = 1'b0;
        m_pause_prev = 1'b0;
    endtask

    task automatic model_step();
        int nst [CH];
        int nleft [CH];
        bit fill_busy;
        int first_wait;
        fill_busy  = 1'b0;
        first_wait = -1;
        for (int i = 0; i < CH; i++) begin
            if (m_st[i] == 2) fill_busy = 1'b1;
            if (m_st[i] == 1 && first_wait < 0) first_wait = i;
        end
        for (int i = 0; i < CH; i++) begin
            nst[i]   = m_st[i];
            nleft[i] = m_left[i];
            if (bus.en !== 1'b1) begin
                nst[i] = 0; nleft[i] = 0;
            end else begin
                case (m_st[i])
                    0: if (bus.start[i] === 1'b1 && !m_paused) begin
                        nst[i] = 1; m_prog[i] = int'(bus.prog);
                    end
                    1: if (!m_paused && !fill_busy && first_wait == i) begin
                        nst[i] = 2; nleft[i] = FILL_T;
                    end
                    2, 3, 4: if (!m_paused) begin
                        nleft[i] = m_left[i] - 1;
                        if (nleft[i] == 0) begin
                            nst[i] = m_st[i] + 1;
                            if (nst[i] == 3)      nleft[i] = RUN_BASE * (m_prog[i] + 1);
                            else if (nst[i] == 4) nleft[i] = DRAIN_T;
                            else                  nleft[i] = 0;
                        end
                    end
                    default: nst[i] = 0;
                endcase
            end
        end
        for (int i = 0; i < CH; i++) begin
            m_st[i] = nst[i]; m_left[i] = nleft[i];
        end
        if (bus.pause === 1'b1 && !m_pause_prev) m_paused = ~m_paused;
        m_pause_prev = (bus.pause === 1'b1);
    endtask

    function automatic logic [3*CH-1:0] exp_state();
        logic [3*CH-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) v[3*i +: 3] = 3'(m_st[i]);
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_busy();
        logic [CH-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) v[i] = (m_st[i] != 0 && m_st[i] != 5);
        return v;
    endfunction

    function automatic logic [CH-1:0] exp_done();
        logic [CH-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) v[i] = (m_st[i] == 5);
        return v;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic reset_all();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        bus.en    = 1'b1;
        bus.start = '0;
        bus.pause = 1'b0;
        bus.prog  = 2'd0;
        model_reset();
        #4;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.en    = 1'($urandom);
            bus.start = CH'($urandom);
            bus.pause = 1'($urandom);
            bus.prog  = 2'($urandom);
            #7;
            checks++;
            if (bus.state !== '0 || bus.busy !== '0 || bus.done !== '0 ||
                bus.paused !== 1'b0 || bus.any_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: state=%h busy=%b done=%b paused=%b any=%b, want all 0",
                         bus.state, bus.busy, bus.done, bus.paused, bus.any_busy);
            end
        end
        @(posedge clk);
        #1;
        bus.en = 1'b1; bus.start = '0; bus.pause = 1'b0; bus.prog = 2'd0;
        model_reset();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (bus.state !== '0 || bus.paused !== 1'b0 || bus.state !== exp_state()) begin
                errors++;
                $display("FAIL reset_release: state=%h paused=%b, want 0 0", bus.state, bus.paused);
            end
        end
    endtask

    task automatic test_single();
        int exp0 [10] = '{1, 2, 2, 3, 3, 3, 4, 4, 5, 0};
        bus.prog  = 2'd0;
        bus.start = 2'b01;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            bus.start = '0;
            checks++;
            if (bus.state[2:0] !== 3'(exp0[k-1]) || bus.done[0] !== (k == 9)) begin
                errors++;
                $display("FAIL single edge %0d: state0=%0d done0=%b, want %0d %b",
                         k, bus.state[2:0], bus.done[0], exp0[k-1], (k == 9));
            end
            checks++;
            if (bus.state !== exp_state() || bus.busy !== exp_busy() ||
                bus.any_busy !== (exp_busy() != '0)) begin
                errors++;
                $display("FAIL single_model edge %0d: state=%h busy=%b, want %h %b",
                         k, bus.state, bus.busy, exp_state(), exp_busy());
            end
        end
    endtask

    task automatic test_prog3();
        int e;
        bus.prog  = 2'd3;
        bus.start = 2'b01;
        for (int k = 1; k <= 19; k++) begin
            cycle();
            bus.start = '0;
            e = (k == 1) ? 1 : (k <= 3) ? 2 : (k <= 15) ? 3 : (k <= 17) ? 4 : (k == 18) ? 5 : 0;
            checks++;
            if (bus.state[2:0] !== 3'(e) || bus.done[0] !== (k == 18)) begin
                errors++;
                $display("FAIL prog3 edge %0d: state0=%0d done0=%b, want %0d %b",
                         k, bus.state[2:0], bus.done[0], e, (k == 18));
            end
        end
    endtask

    task automatic test_back_to_back();
        int e0 [12] = '{1, 2, 2, 3, 3, 3, 4, 4, 5, 0, 0, 0};
        int e1 [12] = '{1, 1, 1, 1, 2, 2, 3, 3, 3, 4, 4, 5};
        bus.prog  = 2'd0;
        bus.start = 2'b11;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            bus.start = '0;
            checks++;
            if (bus.state[2:0] !== 3'(e0[k-1]) || bus.state[5:3] !== 3'(e1[k-1])) begin
                errors++;
                $display("FAIL b2b_state edge %0d: ch0=%0d ch1=%0d, want %0d %0d",
                         k, bus.state[2:0], bus.state[5:3], e0[k-1], e1[k-1]);
            end
            checks++;
            if (bus.done !== {(k == 12), (k == 9)}) begin
                errors++;
                $display("FAIL b2b_done edge %0d: done=%b, want %b", k, bus.done, {(k == 12), (k == 9)});
            end
        end
    endtask

    task automatic test_pause();
        int e;
        bus.prog  = 2'd0;
        bus.start = 2'b01;
        for (int k = 1; k <= 14; k++) begin
            cycle();
            bus.start = '0;
            e = (k == 1) ? 1 : (k <= 3) ? 2 : (k <= 10) ? 3 : (k <= 12) ? 4 : (k == 13) ? 5 : 0;
            checks++;
            if (bus.state[2:0] !== 3'(e) || bus.paused !== (k >= 5 && k <= 8) ||
                bus.done[0] !== (k == 13)) begin
                errors++;
                $display("FAIL pause edge %0d: state0=%0d paused=%b done0=%b, want %0d %b %b",
                         k, bus.state[2:0], bus.paused, bus.done[0], e, (k >= 5 && k <= 8), (k == 13));
            end
            bus.pause = (k == 4 || k == 8);
        end
        bus.pause = 1'b0;
    endtask

    task automatic test_abort();
        bus.prog  = 2'($urandom);
        bus.start = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            bus.start = '0;
            if (k == 5) begin
                checks++;
                if (bus.state !== 6'b010_011) begin
                    errors++;
                    $display("FAIL abort_pre: state=%b, want 010011", bus.state);
                end
            end
            if (k >= 6) begin
                checks++;
                if (bus.state !== '0 || bus.done !== '0 || bus.any_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL abort edge %0d: state=%h done=%b any=%b, want 0 0 0",
                             k, bus.state, bus.done, bus.any_busy);
                end
            end
            bus.en = (k != 5);
        end
        bus.en = 1'b1;
    endtask

    task automatic test_async_reset();
        bus.prog  = 2'd1;
        bus.start = 2'b01;
        cycle();
        bus.start = '0;
        cycle();
        checks++;
        if (bus.state[2:0] !== 3'd2) begin
            errors++;
            $display("FAIL async_pre: state0=%0d, want 2", bus.state[2:0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== '0 || bus.busy !== '0 || bus.any_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: state=%h busy=%b, want 0 0", bus.state, bus.busy);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            bus.en    = ($urandom_range(0, 39) != 0);
            bus.start = CH'($urandom);
            bus.pause = ($urandom_range(0, 9) == 0);
            bus.prog  = 2'($urandom);
            cycle();
            checks++;
            if (bus.state !== exp_state() || bus.busy !== exp_busy() || bus.done !== exp_done() ||
                bus.paused !== m_paused || bus.any_busy !== (exp_busy() != '0)) begin
                errors++;
                $display("FAIL random cyc %0d: state=%h busy=%b done=%b paused=%b any=%b, want %h %b %b %b %b",
                         k, bus.state, bus.busy, bus.done, bus.paused, bus.any_busy,
                         exp_state(), exp_busy(), exp_done(), m_paused, (exp_busy() != '0));
            end
        end
    endtask

    initial begin
        bus.en = 1'b0; bus.start = '0; bus.pause = 1'b0; bus.prog = 2'd0;
        model_reset();
        test_reset();
        reset_all();
        test_single();
        reset_all();
        test_prog3();
        reset_all();
        test_back_to_back();
        reset_all();
        test_pause();
        reset_all();
        test_abort();
        reset_all();
        test_async_reset();
        reset_all();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
